jtframe_rom_nslots: RTL and testbench
=====================================

JTFRAME_ROM_NSLOTS -- requirements
Module: jtframe_rom_nslots

Interface
REQ-001 SHALL have parameter SLOTS, default 4: number of read slots, legal range 1..8.
REQ-002 SHALL have parameter AW, default 17: per-slot address width, legal range 8..22.
REQ-003 SHALL have parameter DW, default 16: slot data width, legal values 8, 16 or 32.
REQ-004 SHALL have parameter RR, default 0: 0 = fixed priority with slot 0 highest; 1 = round-robin.
REQ-005 SHALL have ports, in this order:
- clk  in  1  system clock.
- rst_n  in  1  reset; one clock; reset is synchronous and active-low.
- slot_addr  in  SLOTS*AW  packed slot addresses; slot k uses bits [k*AW +: AW].
- slot_offset  in  SLOTS*22  per-slot SDRAM word offset.
- slot_cs  in  SLOTS  read request, level.
- slot_clr  in  SLOTS  invalidate the slot's stored data.
- slot_dout  out  SLOTS*DW  per-slot data.
- slot_ok  out  SLOTS  data valid for the current address.
- sdram_req  out  1  SDRAM read request.
- sdram_addr  out  22  SDRAM word address.
- sdram_ack  in  1  request accepted.
- data_rdy  in  1  data_read is valid.
- data_read  in  32  SDRAM read data.

Function
REQ-006 SHALL keep, per slot, a latched address, a valid flag and a data register.
REQ-007 SHALL mark a slot pending when slot_cs=1 and the slot is not a hit. A hit means valid=1 and the latched address equals slot_addr.
REQ-008 SHALL form sdram_addr = slot_offset + word address, where the word address is:
- DW=8: addr>>1.
- DW=16: addr.
- DW=32: addr<<1.
- Arithmetic is modulo 2^22.
REQ-009 SHALL run an FSM with states IDLE, WAIT_ACK and WAIT_RDY.
- IDLE: if any slot is pending, select one, latch its address and sdram_addr, assert sdram_req, go to WAIT_ACK.
- WAIT_ACK: hold sdram_req and sdram_addr stable until sdram_ack=1; drop sdram_req on the cycle after ack; go to WAIT_RDY.
- WAIT_RDY: on data_rdy=1, store data, set valid, return to IDLE.
REQ-010 SHALL select slots as follows:
- RR=0: the lowest-index pending slot.
- RR=1: the first pending slot found searching from (last serviced + 1) mod SLOTS.
REQ-011 SHALL extract stored data as follows:
- DW=8: data_read[15:8] when addr[0]=0, data_read[7:0] when addr[0]=1.
- DW=16: data_read[15:0].
- DW=32: data_read[31:0].
REQ-012 SHALL register slot_ok as slot_cs & hit, so slot_ok rises one cycle after the hit condition becomes true.
REQ-013 SHALL hold slot_dout stable until the next data_rdy for that slot.
REQ-014 SHALL complete and store an in-flight transaction even if slot_cs drops or slot_addr changes. slot_ok SHALL stay low on an address mismatch, and a new request SHALL follow in IDLE.
REQ-015 SHALL clear valid on slot_clr=1. If slot_clr coincides with data_rdy for the same slot, clr SHALL win and valid SHALL remain 0.
REQ-016 SHALL ignore data_rdy and sdram_ack while in IDLE.
REQ-017 SHALL issue at most one outstanding SDRAM request.

Reset
REQ-018 SHALL, while rst_n=0 at a clk edge:
- force the FSM to IDLE;
- force sdram_req=0, sdram_addr=0, slot_ok=0, slot_dout=0;
- clear all valid flags and latched addresses;
- set the RR pointer to SLOTS-1.
REQ-019 SHALL abandon any transaction in progress at reset; a data_rdy arriving after reset SHALL be discarded.

Configuration
REQ-020 SHALL honour the macro JTFRAME_ROM_NSLOTS_CACHE_EN:
- Defined: valid and data are retained while slot_cs=0, so re-asserting the same address produces slot_ok one cycle later with no SDRAM access.
- Undefined: valid is cleared on every cycle with slot_cs=0, so each new cs assertion fetches from SDRAM.

Structure
REQ-021 SHALL place the FSM state enum, legal DW values and the 22-bit SDRAM address width constant in shared package jtframe_sdram_pkg.
REQ-022 SHALL implement slot selection as sub-module jtframe_slot_arb (inputs: pending mask, last-served pointer, RR; output: one-hot grant). All other logic SHALL remain in this module.

Verification
REQ-023 SHALL cover the following directed scenarios:
- a) SLOTS=4, DW=16, slot 1 cs, addr 0x00123, offset 0x10_0000 -> sdram_addr=0x10_0123; ack at +2, rdy with 0xBEEF at +5 -> slot_dout[1]=0xBEEF and slot_ok[1]=1 one cycle later.
- b) RR=0, slots 0 and 2 requesting continuously with addresses changing after each fetch -> slot 0 always granted first. RR=1 with the same stimulus -> grants alternate 0, 2, 0, 2.
- c) DW=8, addr 0x0005, data_read=0x0000_A55A -> sdram_addr=0x0002 and slot_dout=0x5A. With addr 0x0004 -> slot_dout=0xA5.
- d) Address changed during WAIT_RDY -> slot_ok stays 0, a second request is issued for the new address, and slot_ok rises only after the second rdy.
- e) rst_n=0 held one cycle during WAIT_RDY, then a late data_rdy -> sdram_req=0, all slot_ok=0, and the late data is not stored.
- f) Cache: cs dropped then re-asserted at the same address -> with the macro, slot_ok=1 after one cycle and no sdram_req; without it, a new sdram_req is issued.

Source files
------------

// File: rtl/jtframe_sdram_pkg.sv
// -----------------------------------------------------------------------------
// jtframe_sdram_pkg
// Shared definitions for the ROM slot controller:
//   - sdram_st_e : states of the SDRAM request sequencer
//   - SDRAM_AW   : width of an SDRAM word address
//   - DW_8/16/32 : slot data widths the controller supports
//   - dw_legal() : true for a supported slot data width
//   - ptr_w()    : bits needed to index N slots (never less than 1)
// -----------------------------------------------------------------------------
package jtframe_sdram_pkg;

   localparam int SDRAM_AW = 22;

   localparam int DW_8  = 8;
   localparam int DW_16 = 16;
   localparam int DW_32 = 32;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_WAIT_ACK = 2'd1,
      ST_WAIT_RDY = 2'd2
   } sdram_st_e;

   function automatic bit dw_legal(input int dw);
      return (dw == DW_8) || (dw == DW_16) || (dw == DW_32);
   endfunction

   function automatic int ptr_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/jtframe_slot_arb.sv
// -----------------------------------------------------------------------------
// jtframe_slot_arb
// Picks one slot out of a pending mask.
//   pending_i : slots that currently need an SDRAM read
//   last_i    : index of the slot served most recently
//   rr_i      : 0 = fixed priority (slot 0 highest), 1 = round-robin
//   grant_o   : one-hot grant, all zeros when nothing is pending
// -----------------------------------------------------------------------------
module jtframe_slot_arb #(
   parameter int SLOTS = 4,
   parameter int PW    = 2
)(
   input  logic [SLOTS-1:0] pending_i,
   input  logic [PW-1:0]    last_i,
   input  logic             rr_i,
   output logic [SLOTS-1:0] grant_o
);

   // Both policies share one circular search: fixed priority simply starts
   // just after the last index, so the scan begins at slot 0.
   always_comb begin
      int         base;
      int         sum;
      logic [PW-1:0] idx;
      logic       found;
      grant_o = '0;
      found   = 1'b0;
      base    = rr_i ? int'(last_i) : SLOTS - 1;
      sum     = 0;
      idx     = '0;
      for (int i = 1; i <= SLOTS; i++) begin
         sum = base + i;
         if (sum >= SLOTS) sum = sum - SLOTS;
         idx = PW'(sum);
         if (!found && pending_i[idx]) begin
            grant_o[idx] = 1'b1;
            found        = 1'b1;
         end
      end
   end

endmodule

// File: rtl/jtframe_rom_nslots.sv
// -----------------------------------------------------------------------------
// jtframe_rom_nslots
// Shares one SDRAM read port among SLOTS ROM read slots. Each slot keeps the
// address and data of its last fetch; a slot whose request does not match its
// stored data raises a read, one at a time, through a small sequencer.
//
// Parameters: SLOTS (1..8), AW (8..22), DW (8/16/32), RR (0 fixed, 1 round-robin)
// Ports:
//   clk, rst_n   : clock, synchronous active-low reset
//   slot_addr    : SLOTS*AW packed slot addresses
//   slot_offset  : SLOTS*22 per-slot SDRAM word offsets
//   slot_cs      : per-slot read request (level)
//   slot_clr     : per-slot invalidate of stored data
//   slot_dout    : SLOTS*DW per-slot data
//   slot_ok      : per-slot data valid for the current address
//   sdram_req    : SDRAM read request
//   sdram_addr   : SDRAM word address
//   sdram_ack    : request accepted
//   data_rdy     : data_read valid
//   data_read    : 32-bit SDRAM read data
//
// Build option: define JTFRAME_ROM_NSLOTS_CACHE_EN to keep stored data valid
// while a slot's cs is low; otherwise every new cs assertion refetches.
// -----------------------------------------------------------------------------
module jtframe_rom_nslots
   import jtframe_sdram_pkg::*;
#(
   parameter int SLOTS = 4,
   parameter int AW    = 17,
   parameter int DW    = 16,
   parameter int RR    = 0
)(
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [SLOTS*AW-1:0]       slot_addr,
   input  logic [SLOTS*SDRAM_AW-1:0] slot_offset,
   input  logic [SLOTS-1:0]          slot_cs,
   input  logic [SLOTS-1:0]          slot_clr,
   output logic [SLOTS*DW-1:0]       slot_dout,
   output logic [SLOTS-1:0]          slot_ok,
   output logic                      sdram_req,
   output logic [SDRAM_AW-1:0]       sdram_addr,
   input  logic                      sdram_ack,
   input  logic                      data_rdy,
   input  logic [31:0]               data_read
);

   localparam int PW = ptr_w(SLOTS);

   // Slot word address as seen by the SDRAM (16-bit words), modulo 2^22.
   function automatic logic [SDRAM_AW-1:0] word_addr(input logic [AW-1:0] a);
      logic [SDRAM_AW-1:0] w;
      w = SDRAM_AW'(a);
      if (DW == DW_8)       return w >> 1;
      else if (DW == DW_32) return w << 1;
      else                  return w;
   endfunction

   // Slot data taken out of a 32-bit SDRAM read. Byte slots use the address
   // LSB to pick the byte inside the 16-bit word (high byte first).
   function automatic logic [DW-1:0] extract(input logic [31:0] d, input logic lsb);
      if (DW == DW_8)       return lsb ? DW'(d[7:0]) : DW'(d[15:8]);
      else if (DW == DW_16) return DW'(d[15:0]);
      else                  return DW'(d);
   endfunction

   sdram_st_e           state_q, state_d;
   logic                req_q;
   logic [SDRAM_AW-1:0] sdaddr_q;
   logic [PW-1:0]       sel_q;
   logic [PW-1:0]       last_q;
   logic [SLOTS-1:0]    valid_q;
   logic [SLOTS-1:0]    ok_q, ok_d;
   logic [AW-1:0]       addr_q [SLOTS];
   logic [DW-1:0]       data_q [SLOTS];

   logic [AW-1:0]       cur_addr [SLOTS];
   logic [SDRAM_AW-1:0] cur_off  [SLOTS];
   logic [SLOTS-1:0]    hit;
   logic [SLOTS-1:0]    pending;
   logic [SLOTS-1:0]    grant;
   logic                gnt_any;
   logic [PW-1:0]       gnt_idx;
   logic [SDRAM_AW-1:0] gnt_sdaddr;
   logic                issue;
   logic                store;

   always_comb begin
      for (int k = 0; k < SLOTS; k++) begin
         cur_addr[k] = slot_addr[k*AW +: AW];
         cur_off[k]  = slot_offset[k*SDRAM_AW +: SDRAM_AW];
      end
   end

   always_comb begin
      hit = '0;
      for (int k = 0; k < SLOTS; k++) begin
         hit[k] = valid_q[k] && (addr_q[k] == cur_addr[k]);
      end
   end

   assign pending = slot_cs & ~hit;
   assign ok_d    = slot_cs & hit;

   jtframe_slot_arb #(
      .SLOTS (SLOTS),
      .PW    (PW)
   ) u_arb (
      .pending_i (pending),
      .last_i    (last_q),
      .rr_i      (RR != 0),
      .grant_o   (grant)
   );

   assign gnt_any = |grant;

   always_comb begin
      gnt_idx = '0;
      for (int k = 0; k < SLOTS; k++) begin
         if (grant[k]) gnt_idx = PW'(k);
      end
   end

   assign gnt_sdaddr = cur_off[gnt_idx] + word_addr(cur_addr[gnt_idx]);

   // Acks and data strobes only matter in the state that waits for them.
   assign issue = (state_q == ST_IDLE)     && gnt_any;
   assign store = (state_q == ST_WAIT_RDY) && data_rdy;

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:     if (gnt_any)   state_d = ST_WAIT_ACK;
         ST_WAIT_ACK: if (sdram_ack) state_d = ST_WAIT_RDY;
         ST_WAIT_RDY: if (data_rdy)  state_d = ST_IDLE;
         default:                    state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         req_q    <= 1'b0;
         sdaddr_q <= '0;
         sel_q    <= '0;
         last_q   <= PW'(SLOTS - 1);
         valid_q  <= '0;
         ok_q     <= '0;
         for (int k = 0; k < SLOTS; k++) begin
            addr_q[k] <= '0;
            data_q[k] <= '0;
         end
      end else begin
         state_q <= state_d;
         ok_q    <= ok_d;

         // Latching a new address invalidates the old data, otherwise the
         // stale data would look like a hit for the new address.
         if (issue) begin
            req_q            <= 1'b1;
            sdaddr_q         <= gnt_sdaddr;
            sel_q            <= gnt_idx;
            last_q           <= gnt_idx;
            addr_q[gnt_idx]  <= cur_addr[gnt_idx];
            valid_q[gnt_idx] <= 1'b0;
         end

         if ((state_q == ST_WAIT_ACK) && sdram_ack) begin
            req_q <= 1'b0;
         end

         // The fetch completes regardless of cs or address changes; a later
         // address mismatch simply makes the slot pending again.
         if (store) begin
            data_q[sel_q]  <= extract(data_read, addr_q[sel_q][0]);
            valid_q[sel_q] <= 1'b1;
         end

         // Invalidation comes last so it overrides a simultaneous store.
         for (int k = 0; k < SLOTS; k++) begin
            if (slot_clr[k]) valid_q[k] <= 1'b0;
`ifdef JTFRAME_ROM_NSLOTS_CACHE_EN
`else
            if (!slot_cs[k]) valid_q[k] <= 1'b0;
`endif
         end
      end
   end

   always_comb begin
      slot_dout = '0;
      for (int k = 0; k < SLOTS; k++) begin
         slot_dout[k*DW +: DW] = data_q[k];
      end
   end

   assign slot_ok    = ok_q;
   assign sdram_req  = req_q;
   assign sdram_addr = sdaddr_q;

endmodule

// File: tb/tb_jtframe_rom_nslots.sv
// -----------------------------------------------------------------------------
// tb_jtframe_rom_nslots
// Two controllers side by side: u_a (4 slots, 16-bit, fixed priority) and
// u_b (4 slots, 8-bit, round-robin). Stimulus pushes the SDRAM address of each
// expected request and the slot/data of each expected slot_ok rise into
// queues; a monitor on the falling edge pops and compares as they appear.
// -----------------------------------------------------------------------------
module tb_jtframe_rom_nslots;

   localparam int AW = 17;

   typedef struct {
      int          slot;
      logic [31:0] data;
   } ok_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;

   logic [4*AW-1:0] a_addr;
   logic [4*22-1:0] a_off;
   logic [3:0]      a_cs, a_clr, a_ok;
   logic [63:0]     a_dout;
   logic            a_req, a_ack, a_rdy;
   logic [21:0]     a_sdaddr;
   logic [31:0]     a_data;

   logic [4*AW-1:0] b_addr;
   logic [4*22-1:0] b_off;
   logic [3:0]      b_cs, b_clr, b_ok;
   logic [31:0]     b_dout;
   logic            b_req, b_ack, b_rdy;
   logic [21:0]     b_sdaddr;
   logic [31:0]     b_data;

   jtframe_rom_nslots #(.SLOTS(4), .AW(AW), .DW(16), .RR(0)) u_a (
      .clk(clk), .rst_n(rst_n), .slot_addr(a_addr), .slot_offset(a_off),
      .slot_cs(a_cs), .slot_clr(a_clr), .slot_dout(a_dout), .slot_ok(a_ok),
      .sdram_req(a_req), .sdram_addr(a_sdaddr), .sdram_ack(a_ack),
      .data_rdy(a_rdy), .data_read(a_data)
   );

   jtframe_rom_nslots #(.SLOTS(4), .AW(AW), .DW(8), .RR(1)) u_b (
      .clk(clk), .rst_n(rst_n), .slot_addr(b_addr), .slot_offset(b_off),
      .slot_cs(b_cs), .slot_clr(b_clr), .slot_dout(b_dout), .slot_ok(b_ok),
      .sdram_req(b_req), .sdram_addr(b_sdaddr), .sdram_ack(b_ack),
      .data_rdy(b_rdy), .data_read(b_data)
   );

   int n_total = 0;
   int n_pass  = 0;

   logic [21:0] qa_req [$];
   logic [21:0] qb_req [$];
   ok_t         qa_ok  [$];
   ok_t         qb_ok  [$];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", nm, act, exp);
   endtask

   task automatic unexpected(input string nm, input logic [31:0] act);
      n_total++;
      $display("FAIL %s: got %h, nothing expected", nm, act);
   endtask

   task automatic push_ok_a(input int s, input logic [31:0] d);
      ok_t e; e.slot = s; e.data = d; qa_ok.push_back(e);
   endtask

   task automatic push_ok_b(input int s, input logic [31:0] d);
      ok_t e; e.slot = s; e.data = d; qb_ok.push_back(e);
   endtask

   task automatic set_a(input int k, input logic [AW-1:0] v);
      a_addr[k*AW +: AW] = v;
   endtask

   task automatic set_b(input int k, input logic [AW-1:0] v);
      b_addr[k*AW +: AW] = v;
   endtask

   task automatic cyc(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   // ---------------- SDRAM side, instance A ----------------
   task automatic a_wait_req();
      int n; n = 0;
      while (a_req !== 1'b1 && n < 64) begin cyc(1); n++; end
      check("a_req_seen", a_req, 1);
   endtask
   task automatic a_do_ack(input int dly);
      cyc(dly);
      check("a_req_held", a_req, 1);
      a_ack = 1'b1; cyc(1); a_ack = 1'b0;
      check("a_req_dropped", a_req, 0);
   endtask
   task automatic a_do_rdy(input int dly, input logic [31:0] d);
      cyc(dly);
      a_data = d; a_rdy = 1'b1; cyc(1); a_rdy = 1'b0;
   endtask
   task automatic a_serve(input int ad, input int rd, input logic [31:0] d);
      a_wait_req(); a_do_ack(ad); a_do_rdy(rd, d);
   endtask

   // ---------------- SDRAM side, instance B ----------------
   task automatic b_wait_req();
      int n; n = 0;
      while (b_req !== 1'b1 && n < 64) begin cyc(1); n++; end
      check("b_req_seen", b_req, 1);
   endtask
   task automatic b_do_ack(input int dly);
      cyc(dly);
      check("b_req_held", b_req, 1);
      b_ack = 1'b1; cyc(1); b_ack = 1'b0;
      check("b_req_dropped", b_req, 0);
   endtask
   task automatic b_do_rdy(input int dly, input logic [31:0] d);
      cyc(dly);
      b_data = d; b_rdy = 1'b1; cyc(1); b_rdy = 1'b0;
   endtask
   task automatic b_serve(input int ad, input int rd, input logic [31:0] d);
      b_wait_req(); b_do_ack(ad); b_do_rdy(rd, d);
   endtask

   // ---------------- monitor ----------------
   logic       a_req_p = 1'b0, b_req_p = 1'b0;
   logic [3:0] a_ok_p  = 4'd0, b_ok_p  = 4'd0;

   always @(negedge clk) begin : mon
      logic [21:0] er;
      ok_t         eo;
      if (a_req === 1'b1 && a_req_p !== 1'b1) begin
         if (qa_req.size() == 0) unexpected("a_req_rise", {10'd0, a_sdaddr});
         else begin er = qa_req.pop_front(); check("a_sdram_addr", {10'd0, a_sdaddr}, {10'd0, er}); end
      end
      if (b_req === 1'b1 && b_req_p !== 1'b1) begin
         if (qb_req.size() == 0) unexpected("b_req_rise", {10'd0, b_sdaddr});
         else begin er = qb_req.pop_front(); check("b_sdram_addr", {10'd0, b_sdaddr}, {10'd0, er}); end
      end
      for (int k = 0; k < 4; k++) begin
         if (a_ok[k] === 1'b1 && a_ok_p[k] !== 1'b1) begin
            if (qa_ok.size() == 0) unexpected("a_ok_rise", k);
            else begin
               eo = qa_ok.pop_front();
               check("a_ok_slot", k, eo.slot);
               check("a_ok_dout", {16'd0, a_dout[k*16 +: 16]}, eo.data);
            end
         end
         if (b_ok[k] === 1'b1 && b_ok_p[k] !== 1'b1) begin
            if (qb_ok.size() == 0) unexpected("b_ok_rise", k);
            else begin
               eo = qb_ok.pop_front();
               check("b_ok_slot", k, eo.slot);
               check("b_ok_dout", {24'd0, b_dout[k*8 +: 8]}, eo.data);
            end
         end
      end
      a_req_p <= a_req;
      b_req_p <= b_req;
      a_ok_p  <= a_ok;
      b_ok_p  <= b_ok;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected summary");
      $fatal(1, "bench timeout");
   end

   // ---------------- stimulus ----------------
   initial begin
      rst_n  = 1'b0;
      a_addr = '0; a_cs = '0; a_clr = '0; a_ack = 1'b0; a_rdy = 1'b0; a_data = '0;
      b_addr = '0; b_cs = '0; b_clr = '0; b_ack = 1'b0; b_rdy = 1'b0; b_data = '0;
      a_off  = {22'h000000, 22'h300000, 22'h100000, 22'h200000};
      b_off  = {22'h000000, 22'h300000, 22'h000000, 22'h200000};
      cyc(3);
      check("a_rst_req",    a_req, 0);
      check("a_rst_addr",   a_sdaddr, 0);
      check("a_rst_ok",     a_ok, 0);
      check("a_rst_dout_l", a_dout[31:0], 0);
      check("a_rst_dout_h", a_dout[63:32], 0);
      check("b_rst_req",    b_req, 0);
      check("b_rst_ok",     b_ok, 0);
      check("b_rst_dout",   b_dout, 0);
      rst_n = 1'b1;
      cyc(2);

      // B: round-robin, served slot's address moves after each fetch
      set_b(0, 'h10); set_b(2, 'h20); b_cs = 4'b0101;
      qb_req.push_back(22'h200008); b_serve(1, 2, 32'h0000_1111); set_b(0, 'h12);
      qb_req.push_back(22'h300010); b_serve(1, 2, 32'h0000_2222); set_b(2, 'h22);
      qb_req.push_back(22'h200009); b_serve(1, 2, 32'h0000_3333); set_b(0, 'h14);
      qb_req.push_back(22'h300011); push_ok_b(2, 32'h4D); b_serve(1, 2, 32'h0000_4D3C);
      qb_req.push_back(22'h20000A); push_ok_b(0, 32'h6E); b_serve(1, 2, 32'h0000_6E2B);
      cyc(4);

      // B: byte lanes, odd address takes low byte, even takes high byte
      set_b(1, 'h0005); b_cs[1] = 1'b1;
      qb_req.push_back(22'h000002); push_ok_b(1, 32'h5A); b_serve(1, 2, 32'h0000_A55A);
      cyc(3);
      set_b(1, 'h0004);
      qb_req.push_back(22'h000002); push_ok_b(1, 32'hA5); b_serve(1, 2, 32'h0000_A55A);
      cyc(3);
      check("b_byte_ok", b_ok[1], 1);
      check("b_byte_dout", b_dout[15:8], 8'hA5);

      // A: basic fetch through slot 1 with offset
      set_a(1, 'h00123); a_cs = 4'b0010;
      qa_req.push_back(22'h100123); push_ok_a(1, 32'hBEEF); a_serve(1, 2, 32'h0000_BEEF);
      cyc(3);
      check("a_basic_ok", a_ok[1], 1);
      check("a_basic_dout", a_dout[31:16], 16'hBEEF);

      // A: fixed priority keeps slot 0 ahead while its address keeps moving
      set_a(0, 'h10); set_a(2, 'h20); a_cs = 4'b0111;
      qa_req.push_back(22'h200010); a_serve(1, 2, 32'h0000_1001); set_a(0, 'h11);
      qa_req.push_back(22'h200011); a_serve(1, 2, 32'h0000_1002); set_a(0, 'h12);
      qa_req.push_back(22'h200012); push_ok_a(0, 32'h1003); a_serve(1, 2, 32'h0000_1003);
      qa_req.push_back(22'h300020); push_ok_a(2, 32'h1004); a_serve(1, 2, 32'h0000_1004);
      cyc(3);

      // A: address moves while waiting for data
      set_a(3, 'h100); a_cs[3] = 1'b1;
      qa_req.push_back(22'h000100);
      a_wait_req(); a_do_ack(1); set_a(3, 'h200); a_do_rdy(2, 32'h0000_1111);
      qa_req.push_back(22'h000200); push_ok_a(3, 32'h2222);
      a_wait_req();
      check("a_moved_ok_low", a_ok[3], 0);
      a_do_ack(1); a_do_rdy(2, 32'h0000_2222);
      cyc(3);

      // A: cs dropped and re-asserted at the same address
      a_cs[1] = 1'b0; cyc(3); a_cs[1] = 1'b1;
`ifdef JTFRAME_ROM_NSLOTS_CACHE_EN
      push_ok_a(1, 32'hBEEF);
      cyc(3);
      check("a_cache_no_req", a_req, 0);
      check("a_cache_ok", a_ok[1], 1);
`else
      qa_req.push_back(22'h100123); push_ok_a(1, 32'h4444); a_serve(1, 2, 32'h0000_4444);
      cyc(3);
`endif

      // A: clear forces a refetch
      a_clr[1] = 1'b1; cyc(1); a_clr[1] = 1'b0;
      qa_req.push_back(22'h100123); push_ok_a(1, 32'h5555); a_serve(1, 2, 32'h0000_5555);
      cyc(3);
      check("a_clr_dout", a_dout[31:16], 16'h5555);

      // A: reset in the middle of a transaction, then a stray data strobe
      set_a(0, 'h50);
      qa_req.push_back(22'h200050);
      a_wait_req(); a_do_ack(1); cyc(1);
      rst_n = 1'b0; a_cs = '0; b_cs = '0; cyc(1); rst_n = 1'b1;
      check("a_rst2_req", a_req, 0);
      check("a_rst2_ok",  a_ok, 0);
      cyc(1);
      a_data = 32'h0000_7777; a_rdy = 1'b1; cyc(1); a_rdy = 1'b0;
      cyc(3);
      check("a_late_dout_l", a_dout[31:0], 0);
      check("a_late_dout_h", a_dout[63:32], 0);
      check("a_late_ok",     a_ok, 0);
      check("a_late_req",    a_req, 0);

      cyc(5);
      check("qa_req_left", qa_req.size(), 0);
      check("qb_req_left", qb_req.size(), 0);
      check("qa_ok_left",  qa_ok.size(), 0);
      check("qb_ok_left",  qb_ok.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
